// File: rtl/ping_pong_ctrl.sv
// Game sequencer for the LED ping-pong ball: turns paddle presses into serves,
// returns and misses, paces the ball with a tick divider, and keeps score.
module ping_pong_ctrl #(
  parameter int TICK_DIV    = 12_500_000,
  parameter int POINT_TICKS = 4,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk_game,
  input  logic       rst_n,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [5:0] counter,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PT_W  = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(POINT_TICKS - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [5:0] POS_L      = 6'd16;
  localparam logic [5:0] POS_R      = 6'd1;
  localparam logic [5:0] CODE_IDLE  = 6'd0;
  localparam logic [5:0] CODE_POINT = 6'd17;
  localparam logic [5:0] CODE_OVER  = 6'd18;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_counter, w_counter_nxt;
  logic [3:0]       r_score_l, w_score_l_nxt;
  logic [3:0]       r_score_r, w_score_r_nxt;
  logic             r_game_over, w_game_over_nxt;
  logic             r_winner, w_winner_nxt;
  logic             r_dir, w_dir_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [PT_W-1:0]  r_pt_cnt, w_pt_cnt_nxt;
  logic             r_prev_l, r_prev_r;
  logic             w_press_l, w_press_r, w_tick;
  logic             w_miss_l, w_miss_r;

  assign w_press_l = btn_l & ~r_prev_l;
  assign w_press_r = btn_r & ~r_prev_r;
  assign w_tick    = (r_div == DIV_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_counter_nxt   = r_counter;
    w_score_l_nxt   = r_score_l;
    w_score_r_nxt   = r_score_r;
    w_game_over_nxt = r_game_over;
    w_winner_nxt    = r_winner;
    w_dir_nxt       = r_dir;
    w_div_nxt       = w_tick ? '0 : r_div + 1'b1;
    w_pt_cnt_nxt    = r_pt_cnt;
    w_miss_l        = 1'b0;
    w_miss_r        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_press_l) begin
          w_counter_nxt = POS_L;
          w_dir_nxt     = 1'b1;
          w_div_nxt     = '0;
          w_state_nxt   = S_PLAY;
        end else if (w_press_r) begin
          w_counter_nxt = POS_R;
          w_dir_nxt     = 1'b0;
          w_div_nxt     = '0;
          w_state_nxt   = S_PLAY;
        end
      end

      S_PLAY: begin
        // Only the receiving player's press matters; a return beats a same-cycle tick.
        if (r_dir) begin
          if (w_press_r) begin
            if (r_counter == POS_R) begin
              w_dir_nxt = 1'b0;
              if (w_tick) w_counter_nxt = POS_R + 6'd1;
            end else begin
              w_miss_r = 1'b1;
            end
          end else if (w_tick) begin
            if (r_counter == POS_R) w_miss_r = 1'b1;
            else                    w_counter_nxt = r_counter - 6'd1;
          end
        end else begin
          if (w_press_l) begin
            if (r_counter == POS_L) begin
              w_dir_nxt = 1'b1;
              if (w_tick) w_counter_nxt = POS_L - 6'd1;
            end else begin
              w_miss_l = 1'b1;
            end
          end else if (w_tick) begin
            if (r_counter == POS_L) w_miss_l = 1'b1;
            else                    w_counter_nxt = r_counter + 6'd1;
          end
        end

        if (w_miss_l || w_miss_r) begin
          if (w_miss_r) w_score_l_nxt = r_score_l + 4'd1;
          else          w_score_r_nxt = r_score_r + 4'd1;
          w_counter_nxt = CODE_POINT;
          w_div_nxt     = '0;
          w_pt_cnt_nxt  = '0;
          w_state_nxt   = S_POINT;
        end
      end

      S_POINT: begin
        if (w_tick) begin
          if (r_pt_cnt == PT_LAST) begin
            w_div_nxt = '0;
            if ((r_score_l == WIN) || (r_score_r == WIN)) begin
              w_state_nxt     = S_OVER;
              w_counter_nxt   = CODE_OVER;
              w_game_over_nxt = 1'b1;
              w_winner_nxt    = (r_score_r == WIN);
            end else begin
              w_state_nxt   = S_IDLE;
              w_counter_nxt = CODE_IDLE;
            end
          end else begin
            w_pt_cnt_nxt = r_pt_cnt + 1'b1;
          end
        end
      end

      S_OVER: begin
        if (w_press_l || w_press_r) begin
          w_state_nxt     = S_IDLE;
          w_counter_nxt   = CODE_IDLE;
          w_score_l_nxt   = 4'd0;
          w_score_r_nxt   = 4'd0;
          w_game_over_nxt = 1'b0;
          w_winner_nxt    = 1'b0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_game or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_counter   <= CODE_IDLE;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
      r_dir       <= 1'b0;
      r_div       <= '0;
      r_pt_cnt    <= '0;
      r_prev_l    <= 1'b0;
      r_prev_r    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_counter   <= w_counter_nxt;
      r_score_l   <= w_score_l_nxt;
      r_score_r   <= w_score_r_nxt;
      r_game_over <= w_game_over_nxt;
      r_winner    <= w_winner_nxt;
      r_dir       <= w_dir_nxt;
      r_div       <= w_div_nxt;
      r_pt_cnt    <= w_pt_cnt_nxt;
      r_prev_l    <= btn_l;
      r_prev_r    <= btn_r;
    end
  end

  assign counter   = r_counter;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Directed and randomized bench for ping_pong_ctrl; every cycle is checked
// against a rule-level model of the game (ball position, velocity, scores).
module tb_ping_pong_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int POINT_TICKS = 2;
  localparam int WIN_SCORE   = 2;

  logic       clkGame = 1'b0;
  logic       rstN    = 1'b1;
  logic       btnL, btnR;
  logic [5:0] counter;
  logic [3:0] scoreL, scoreR;
  logic       gameOver, winner;

  int passCount  = 0;
  int totalCount = 0;

  // Model: phase 0 idle, 1 rally, 2 point shown, 3 game over; velocity -1 heads to position 1.
  int mPhase, mPos, mVel, mScoreL, mScoreR, mOver, mWinner, mSince, mPointTicks;
  bit mPrevL, mPrevR;

  ping_pong_ctrl #(
    .TICK_DIV(TICK_DIV),
    .POINT_TICKS(POINT_TICKS),
    .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk_game(clkGame),
    .rst_n(rstN),
    .btn_l(btnL),
    .btn_r(btnR),
    .counter(counter),
    .score_l(scoreL),
    .score_r(scoreR),
    .game_over(gameOver),
    .winner(winner)
  );

  always #5 clkGame = ~clkGame;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    mPhase = 0; mPos = 0; mVel = 1; mScoreL = 0; mScoreR = 0;
    mOver = 0; mWinner = 0; mSince = 0; mPointTicks = 0;
    mPrevL = 0; mPrevR = 0;
  endtask

  task automatic modelCycle(input bit l, input bit r);
    bit pressL, pressR, tick, restart, recvPress, atEnd;
    int endPos;
    pressL  = l && !mPrevL;
    pressR  = r && !mPrevR;
    tick    = (mSince % TICK_DIV) == (TICK_DIV - 1);
    restart = 0;
    case (mPhase)
      0: begin
        if (pressL)      begin mPos = 16; mVel = -1; mPhase = 1; restart = 1; end
        else if (pressR) begin mPos = 1;  mVel = 1;  mPhase = 1; restart = 1; end
      end
      1: begin
        endPos    = (mVel < 0) ? 1 : 16;
        recvPress = (mVel < 0) ? pressR : pressL;
        atEnd     = (mPos == endPos);
        if (recvPress && atEnd) begin
          mVel = -mVel;
          if (tick) mPos += mVel;
        end else if (recvPress || (tick && atEnd)) begin
          if (mVel < 0) mScoreL++; else mScoreR++;
          mPos = 17; mPhase = 2; mPointTicks = 0; restart = 1;
        end else if (tick) begin
          mPos += mVel;
        end
      end
      2: begin
        if (tick) begin
          mPointTicks++;
          if (mPointTicks == POINT_TICKS) begin
            restart = 1;
            if (mScoreL == WIN_SCORE || mScoreR == WIN_SCORE) begin
              mPhase = 3; mPos = 18; mOver = 1; mWinner = (mScoreR == WIN_SCORE);
            end else begin
              mPhase = 0; mPos = 0;
            end
          end
        end
      end
      default: begin
        if (pressL || pressR) begin
          mPhase = 0; mPos = 0; mScoreL = 0; mScoreR = 0; mOver = 0; mWinner = 0;
        end
      end
    endcase
    mPrevL = l;
    mPrevR = r;
    mSince = restart ? 0 : mSince + 1;
  endtask

  task automatic applyStimulus(input bit l, input bit r);
    btnL = l;
    btnR = r;
    @(posedge clkGame);
    #1;
    modelCycle(l, r);
    checkOutput("counter", counter, mPos);
    checkOutput("scoreL", scoreL, mScoreL);
    checkOutput("scoreR", scoreR, mScoreR);
    checkOutput("gameOver", gameOver, mOver);
    checkOutput("winner", winner, mWinner);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0);
  endtask

  // Reset is checked before any clock edge so its asynchronous effect is what is seen.
  task automatic resetDut();
    btnL = 0;
    btnR = 0;
    rstN = 0;
    #1;
    checkOutput("rstCounter", counter, 0);
    checkOutput("rstScoreL", scoreL, 0);
    checkOutput("rstScoreR", scoreR, 0);
    checkOutput("rstGameOver", gameOver, 0);
    checkOutput("rstWinner", winner, 0);
    modelReset();
    @(posedge clkGame);
    #1;
    rstN = 1;
  endtask

  initial begin
    bit l, r;
    btnL = 0;
    btnR = 0;
    modelReset();
    #3;
    resetDut();

    idleCycles(100);
    checkOutput("idleCounter", counter, 0);
    checkOutput("idleGameOver", gameOver, 0);

    applyStimulus(1, 0);
    checkOutput("serveL", counter, 16);
    idleCycles(3);
    checkOutput("noStepYet", counter, 16);
    idleCycles(1);
    checkOutput("firstStep", counter, 15);
    idleCycles(56);
    checkOutput("reachRight", counter, 1);
    idleCycles(4);
    checkOutput("missCode", counter, 17);
    checkOutput("missScoreL", scoreL, 1);
    idleCycles(7);
    checkOutput("pointHeld", counter, 17);
    idleCycles(1);
    checkOutput("pointEnd", counter, 0);

    resetDut();
    applyStimulus(1, 0);
    idleCycles(60);
    checkOutput("retAt1", counter, 1);
    applyStimulus(0, 1);
    checkOutput("retHold", counter, 1);
    idleCycles(3);
    checkOutput("retStep", counter, 2);
    applyStimulus(0, 1);
    idleCycles(3);
    checkOutput("ignoredR", counter, 3);
    checkOutput("ignoredScore", scoreL, 0);
    idleCycles(52);
    checkOutput("reachLeft", counter, 16);
    applyStimulus(1, 0);
    idleCycles(3);
    checkOutput("leftRet", counter, 15);
    idleCycles(56);
    checkOutput("backAt1", counter, 1);
    idleCycles(3);
    applyStimulus(0, 1);
    checkOutput("tickReturn", counter, 2);
    checkOutput("tickRetScore", scoreL, 0);

    resetDut();
    applyStimulus(1, 0);
    idleCycles(44);
    checkOutput("at5", counter, 5);
    applyStimulus(0, 1);
    checkOutput("earlyCode", counter, 17);
    checkOutput("earlyScoreL", scoreL, 1);

    resetDut();
    applyStimulus(1, 0);
    for (int i = 0; i < 200; i++) applyStimulus(1, 0);
    checkOutput("heldCounter", counter, 0);
    checkOutput("heldScoreR", scoreR, 0);
    checkOutput("heldScoreL", scoreL, 1);

    resetDut();
    applyStimulus(0, 1);
    checkOutput("serveR", counter, 1);
    idleCycles(64);
    checkOutput("leftMiss1", scoreR, 1);
    idleCycles(8);
    applyStimulus(0, 1);
    idleCycles(64);
    checkOutput("leftMiss2", scoreR, 2);
    idleCycles(8);
    checkOutput("overCode", counter, 18);
    checkOutput("overFlag", gameOver, 1);
    checkOutput("overWinner", winner, 1);
    checkOutput("overScoreR", scoreR, 2);
    applyStimulus(0, 1);
    checkOutput("restartCode", counter, 0);
    checkOutput("restartScoreR", scoreR, 0);
    checkOutput("restartOver", gameOver, 0);

    resetDut();
    applyStimulus(1, 0);
    idleCycles(28);
    checkOutput("at9", counter, 9);
    resetDut();

    // Receivers press more often when the ball sits at their end, so returns actually happen.
    for (int i = 0; i < 2000; i++) begin
      l = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 7) == 0);
      if (mPhase == 1 && mPos == 1 && mVel < 0)  r = ($urandom_range(0, 1) == 0);
      if (mPhase == 1 && mPos == 16 && mVel > 0) l = ($urandom_range(0, 1) == 0);
      applyStimulus(l, r);
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/ping_pong_ctrl.md
# ping_pong_ctrl

Game sequencer for the LED ping-pong ball. It generates the 6-bit position code consumed by the LED decoder: 0 idle, 1..16 ball position, 17 point scored, 18 game over. It turns the two paddle buttons into serves, returns and misses, keeps per-player scores and declares a winner. Ball motion is paced by an internal tick divider running on `clk_game`.

## Interface
- `TICK_DIV`, default 12_500_000: `clk_game` cycles per ball step; minimum 2.
- `POINT_TICKS`, default 4: ticks the point pattern (code 17) is held.
- `WIN_SCORE`, default 7: score that ends the game; range 1..15.
- `clk_game`  in  1  game clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_l`  in  1  left paddle, level, already debounced and synchronous to `clk_game`; left end is position 16.
- `btn_r`  in  1  right paddle, same conditioning; right end is position 1.
- `counter`  out  6  position/pattern code to the LED decoder; registered.
- `score_l`  out  4  left score; registered.
- `score_r`  out  4  right score; registered.
- `game_over`  out  1  high in OVER; registered.
- `winner`  out  1  0 = left, 1 = right; valid while `game_over`=1, otherwise 0.

## Operation
- Press detection: one flop per button holds its previous value. A press is `btn`=1 with prev=0. A held button never retriggers.
- Tick: the divider counts 0..TICK_DIV-1. `tick` is asserted in the cycle the divider equals TICK_DIV-1, and the divider then wraps to 0. The divider is forced to 0 on a serve, on POINT entry and on POINT exit.
- `dir`: 1 = moving toward position 1 (rightward), 0 = moving toward position 16.
- IDLE (counter=0):
  - Press on `btn_l` serves: counter=16, dir=1, go to PLAY.
  - Press on `btn_r` serves: counter=1, dir=0, go to PLAY.
  - Both pressed in the same cycle: left serves.
- PLAY (counter=1..16):
  - Right return: a `btn_r` press with counter=1 and dir=1 sets dir=0.
  - Left return: a `btn_l` press with counter=16 and dir=0 sets dir=1.
  - Early press: a `btn_r` press with dir=1 and counter≠1 is a right miss. A `btn_l` press with dir=0 and counter≠16 is a left miss.
  - Presses by the player the ball is moving away from are ignored.
  - On `tick`, the ball steps one position in `dir`. A tick at counter=1 with dir=1 is a right miss. A tick at counter=16 with dir=0 is a left miss.
  - A return and a tick in the same cycle: the return wins, and the ball steps away in that same cycle (1→2 or 16→15).
  - A left miss and a right miss cannot occur in the same cycle. If an early press and a tick-miss coincide, the result is a single miss.
- Miss: the opponent's score increments by 1, counter=17, go to POINT. A left miss scores for right; a right miss scores for left.
- POINT (counter=17): buttons are ignored (prev flops still track). After POINT_TICKS ticks:
  - If either score equals WIN_SCORE, go to OVER with counter=18, `game_over`=1, `winner`=scorer.
  - Otherwise go to IDLE.
- OVER (counter=18): a press on either button clears both scores, `game_over` and `winner`, and goes to IDLE with counter=0.
- Codes 19..63 are never driven. Scores never exceed WIN_SCORE.

## Timing
- Reset values: counter=0, score_l=0, score_r=0, game_over=0, winner=0, dir=0, divider=0, prev flops=0, state IDLE.
- Reset takes effect immediately, in any state, including mid-rally and during POINT.
- Latency: a press in cycle N (input high, prev low) updates registered outputs at the edge ending cycle N, so the new value is visible in N+1.
- Tick-driven changes update on the same edge as the `tick` cycle.
- After a serve, the first step occurs TICK_DIV cycles later.
- Score increment and counter=17 appear on the same edge.
- POINT lasts exactly POINT_TICKS×TICK_DIV cycles.

## Test plan
Run all scenarios with TICK_DIV=4, POINT_TICKS=2, WIN_SCORE=2.
- Reset then idle: rst_n low, then release with no presses → counter=0, scores 0/0, game_over=0 for 100 cycles.
- Serve and miss:
  - Pulse btn_l for 1 cycle → counter=16 next cycle, then 15, 14, … 1, one step every 4 cycles.
  - At the tick after counter=1 → counter=17 and score_l=1.
  - 8 cycles later → counter=0.
- Return window:
  - Serve from the left; when counter=1, pulse btn_r → ball travels 1→2…16.
  - Pulse btn_r while the ball is returning → no effect.
  - Pulse btn_r in the same cycle as the tick at counter=1 → next counter=2.
- Early press: serve from the left; at counter=5 pulse btn_r → counter=17 and score_l increments.
- Held button: after a serve, hold btn_l high for 200 cycles → no second serve and no left miss from the hold.
- Game over and restart:
  - Give left two misses → after the second POINT, counter=18, game_over=1, winner=1, score_r=2.
  - Press btn_r → scores 0/0 and counter=0.
  - Assert rst_n low mid-rally at counter=9 → all outputs return to their reset values at once.
